boot_host: RTL and testbench
============================

Name: boot_host

Overview:
- Host-side counterpart of the UART boot loader.
- Streams a program image from a local source memory as bytes, high byte first per word, over a byte-level TX handshake.
- Pulses scan_memory so the loader dumps its RAM, then receives the dump byte-by-byte and compares each word against the source image.
- Used as a self-checking loader driver in the FPGA test harness and in simulation benches, sitting between a source ROM and UART send/receive byte interfaces.

Parameters:
RAM_ADR_WIDTH, 6, width of word address into the source image and the loader RAM
RAM_SIZE, 64, number of 16-bit words transferred in each direction
TIMEOUT_CYCLES, 4000000, ce-qualified cycles without an rx byte before readback aborts (counter width 32)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ce  in  1  clock enable; all registers hold when low
start  in  1  begin a transfer; sampled only in IDLE
src_adr  out  RAM_ADR_WIDTH  source image word address
src_data  in  16  source word, valid one ce cycle after src_adr changes (synchronous ROM)
tx_byte  out  8  byte to UART sender
tx_valid  out  1  tx_byte valid; held until accepted
tx_ready  in  1  UART sender can accept a byte
rx_byte  in  8  byte from UART receiver
rx_valid  in  1  single-cycle strobe, rx_byte valid
scan_memory  out  1  request loader RAM dump
busy  out  1  high outside IDLE/DONE
done  out  1  transfer finished; held until next start
pass  out  1  valid when done: all words matched and no timeout
error_count  out  RAM_ADR_WIDTH+1  number of mismatching words
timeout  out  1  readback aborted due to rx silence

Behaviour:
- Reset values:
  - src_adr = 0, tx_byte = 0, tx_valid = 0, scan_memory = 0, busy = 0, done = 0, pass = 0, error_count = 0, timeout = 0.
  - State returns to IDLE and all counters clear, including when rst is asserted mid-transfer.
- All state updates require ce = 1. A TX transfer occurs when tx_valid & tx_ready & ce. rx_valid is honoured only when ce = 1.
- States:
  - IDLE: on start, clear word index, error_count, done, pass and timeout; set busy; go to FETCH.
  - FETCH: drive src_adr = word index; go to LOAD.
  - LOAD: latch src_data into the word register; go to SEND_HI.
  - SEND_HI: tx_byte = word[15:8] and tx_valid = 1; on transfer, go to SEND_LO.
  - SEND_LO: tx_byte = word[7:0] and tx_valid = 1; on transfer, go to FETCH with index+1. If index == RAM_SIZE-1, go to SCAN instead with index = 0.
  - SCAN: scan_memory = 1 for exactly one ce cycle; clear the timeout counter; go to RX_HI.
  - RX_HI: drive src_adr = index; on rx_valid, capture rx_byte as the high byte and go to RX_LO.
  - RX_LO: on rx_valid, capture the low byte and go to COMPARE.
  - COMPARE: compare {hi, lo} with src_data (already stable, since src_adr has been held since RX_HI).
    - On mismatch, increment error_count, saturating at RAM_SIZE.
    - If index == RAM_SIZE-1, go to DONE; else index+1 and go to RX_HI.
  - DONE: busy = 0, done = 1, pass = (error_count == 0) & ~timeout; on start, re-enter as from IDLE.
- tx_valid deasserts in the cycle following the transfer of the low byte of each word. Minimum spacing between words is FETCH+LOAD = 2 ce cycles.
- Timeout:
  - The counter runs in RX_HI and RX_LO and clears on every accepted rx byte.
  - When it reaches TIMEOUT_CYCLES-1: timeout = 1, pass = 0, go to DONE; error_count is kept.
- rx_valid outside RX_HI/RX_LO is ignored, so stray bytes during the send phase are dropped.
- tx_ready low indefinitely stalls the block in SEND_*, with no timeout on the TX side.
- start while busy is ignored.
- Word index wraps only through the explicit RAM_SIZE-1 check; RAM_SIZE may be less than 2^RAM_ADR_WIDTH.

Decomposition:
- Shared package: state encoding constants (4-bit: IDLE, FETCH, LOAD, SEND_HI, SEND_LO, SCAN, RX_HI, RX_LO, COMPARE, DONE) and the byte-order constant (high byte first). The loader's byte/word converters use the same package.
- One natural sub-module: boot_host_timeout, a loadable cycle counter with clear, enable and an expiry strobe.

Test Plan:
- ROM word i = 16'hA500+i, tx_ready held 1, loopback model echoes the image after scan_memory → 128 tx bytes in order A5,00,A5,01,…; exactly one scan_memory pulse; done = 1, pass = 1, error_count = 0.
- Same run, but the echo model corrupts words 3 and 63 → done = 1, pass = 0, error_count = 2.
- tx_ready toggled pseudo-randomly, ce low 1 cycle in 3 → identical byte sequence, with no byte duplicated or dropped.
- Echo stops after 10 words with TIMEOUT_CYCLES = 1000 → timeout = 1, pass = 0, done asserted 1000 ce cycles after the last byte.
- rst asserted during SEND_LO of word 20 → all outputs at reset values next cycle; a new start resends from word 0.
- rx_valid pulses during the send phase plus start pulses while busy → no effect, and the final result is still pass = 1.

Source files
------------

// File: rtl/boot_host_pkg.sv
// Shared definitions for the UART boot host: state encoding and byte ordering.
// The loader-side byte/word converters import the same package.
package boot_host_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    LOAD    = 4'd2,
    SEND_HI = 4'd3,
    SEND_LO = 4'd4,
    SCAN    = 4'd5,
    RX_HI   = 4'd6,
    RX_LO   = 4'd7,
    COMPARE = 4'd8,
    DONE    = 4'd9
  } state_t;

  localparam bit HIGH_BYTE_FIRST = 1'b1;

  // Byte of a word that goes on the wire first (first = 1) or second (first = 0).
  function automatic logic [7:0] word_byte(input logic [15:0] word, input logic first);
    if (first == HIGH_BYTE_FIRST) return word[15:8];
    else return word[7:0];
  endfunction

  function automatic logic [15:0] join_bytes(input logic [7:0] first_byte,
                                             input logic [7:0] second_byte);
    if (HIGH_BYTE_FIRST) return {first_byte, second_byte};
    else return {second_byte, first_byte};
  endfunction

endpackage

// File: rtl/boot_host_timeout.sv
// Clock-enabled cycle counter with synchronous clear; expired strobes when the
// enabled count sits on LIMIT-1, and the count holds there until cleared.
module boot_host_timeout #(
  parameter int          WIDTH = 32,
  parameter int unsigned LIMIT = 4000000
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (ce) begin
      if (clear) count <= '0;
      else if (enable && !expired) count <= count + WIDTH'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/boot_host.sv
// Host side of the UART boot loader: streams a source image out high byte first,
// requests a RAM dump, and compares the returned words against the image.
module boot_host
  import boot_host_pkg::*;
#(
  parameter int          RAM_ADR_WIDTH  = 6,
  parameter int          RAM_SIZE       = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     start,
  output logic [RAM_ADR_WIDTH-1:0] src_adr,
  input  logic [15:0]              src_data,
  output logic [7:0]               tx_byte,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  output logic                     scan_memory,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [RAM_ADR_WIDTH:0]   error_count,
  output logic                     timeout
);

  localparam logic [RAM_ADR_WIDTH-1:0] LAST_INDEX = RAM_ADR_WIDTH'(RAM_SIZE - 1);
  localparam logic [RAM_ADR_WIDTH:0]   ERR_MAX    = (RAM_ADR_WIDTH + 1)'(RAM_SIZE);

  state_t                   state, state_next;
  logic [RAM_ADR_WIDTH-1:0] index, index_next;
  logic [15:0]              word, word_next;
  logic [7:0]               rx_first, rx_first_next;
  logic [7:0]               rx_second, rx_second_next;
  logic [RAM_ADR_WIDTH:0]   errors_next;
  logic                     done_next, timeout_next;
  logic                     tmo_clear, tmo_enable, tmo_expired;
  logic                     last_word;

  boot_host_timeout #(
    .WIDTH (32),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  assign last_word = (index == LAST_INDEX);
  assign src_adr   = index;
  assign busy      = (state != IDLE) && (state != DONE);
  assign pass      = done && (error_count == '0) && !timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      index       <= '0;
      word        <= '0;
      rx_first    <= '0;
      rx_second   <= '0;
      error_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else if (ce) begin
      state       <= state_next;
      index       <= index_next;
      word        <= word_next;
      rx_first    <= rx_first_next;
      rx_second   <= rx_second_next;
      error_count <= errors_next;
      done        <= done_next;
      timeout     <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state;
    index_next     = index;
    word_next      = word;
    rx_first_next  = rx_first;
    rx_second_next = rx_second;
    errors_next    = error_count;
    done_next      = done;
    timeout_next   = timeout;
    tmo_clear      = 1'b0;
    tmo_enable     = 1'b0;
    tx_byte        = '0;
    tx_valid       = 1'b0;
    scan_memory    = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          index_next   = '0;
          errors_next  = '0;
          done_next    = 1'b0;
          timeout_next = 1'b0;
          state_next   = FETCH;
        end
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        word_next  = src_data;
        state_next = SEND_HI;
      end
      SEND_HI: begin
        tx_byte  = word_byte(word, 1'b1);
        tx_valid = 1'b1;
        if (tx_ready) state_next = SEND_LO;
      end
      SEND_LO: begin
        tx_byte  = word_byte(word, 1'b0);
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (last_word) begin
            index_next = '0;
            state_next = SCAN;
          end else begin
            index_next = index + 1'b1;
            state_next = FETCH;
          end
        end
      end
      SCAN: begin
        scan_memory = 1'b1;
        tmo_clear   = 1'b1;
        state_next  = RX_HI;
      end
      RX_HI, RX_LO: begin
        if (rx_valid) begin
          tmo_clear = 1'b1;
          if (state == RX_HI) begin
            rx_first_next = rx_byte;
            state_next    = RX_LO;
          end else begin
            rx_second_next = rx_byte;
            state_next     = COMPARE;
          end
        end else begin
          tmo_enable = 1'b1;
          // Silence on the receive side aborts readback but keeps errors seen so far.
          if (tmo_expired) begin
            timeout_next = 1'b1;
            done_next    = 1'b1;
            state_next   = DONE;
          end
        end
      end
      COMPARE: begin
        if ((join_bytes(rx_first, rx_second) != src_data) && (error_count != ERR_MAX))
          errors_next = error_count + 1'b1;
        if (last_word) begin
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          index_next = index + 1'b1;
          state_next = RX_HI;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_boot_host.sv
// Randomized scoreboard bench for boot_host: a stimulus process plays the UART
// sender, the ROM and the loader echo; a monitor process checks every output.
module tb_boot_host;

  localparam int AW         = 6;
  localparam int N          = 64;
  localparam int TMO        = 1000;
  localparam int RUN_BUDGET = 40000;

  typedef struct packed {
    logic [7:0] errs;
    logic       tmo;
    logic       pass_exp;
  } result_t;

  logic          clk = 1'b0;
  logic          rst, ce, start, tx_ready, rx_valid;
  logic [7:0]    rx_byte, tx_byte;
  logic [AW-1:0] src_adr;
  logic [15:0]   src_data;
  logic          tx_valid, scan_memory, busy, done, pass, timeout;
  logic [AW:0]   error_count;

  boot_host #(
    .RAM_ADR_WIDTH  (AW),
    .RAM_SIZE       (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .start       (start),
    .src_adr     (src_adr),
    .src_data    (src_data),
    .tx_byte     (tx_byte),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .scan_memory (scan_memory),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .error_count (error_count),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [N];
  logic [15:0] echo_words [N];

  // Synchronous source ROM.
  always @(posedge clk) if (ce) src_data <= rom[src_adr];

  logic [7:0] exp_tx [$];
  result_t    exp_res [$];
  logic [7:0] rx_q [$];

  // Stimulus-side state.
  int run_id = 0, cyc = 0, gap = 0, stim_fails = 0, stop_words = N;
  int ready_mode = 0, ce_mode = 0;
  bit stray_mode = 0, echo_armed = 0, start_pending = 0;

  // Monitor-side state.
  int checks = 0, errors = 0;
  int runs_completed = 0, seen_run = 0, run_cycles = 0;
  int tx_count = 0, scan_count = 0, since_rx = 0;
  bit awaiting = 0;
  logic done_q = 1'b0, scan_q = 1'b0;
  result_t r;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (run_id != seen_run) begin
      seen_run   = run_id;
      awaiting   = 1;
      run_cycles = 0;
      tx_count   = 0;
      scan_count = 0;
      since_rx   = 0;
    end
    if (rst) begin
      check_output("reset_outputs",
                   {src_adr, tx_byte, tx_valid, scan_memory, busy, done, pass, error_count, timeout},
                   32'd0);
    end else begin
      if (ce && tx_valid && tx_ready) begin
        tx_count++;
        check_output("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) check_output("tx_byte", tx_byte, exp_tx.pop_front());
      end
      if (scan_memory && !scan_q) scan_count++;
      if (ce && rx_valid) since_rx = 0;
      else if (ce) since_rx++;
      if (awaiting) begin
        run_cycles++;
        if (done && !done_q) begin
          check_output("result_expected", exp_res.size() != 0, 1);
          if (exp_res.size() != 0) begin
            r = exp_res.pop_front();
            check_output("done_error_count", error_count, r.errs);
            check_output("done_timeout", timeout, r.tmo);
            check_output("done_pass", pass, r.pass_exp);
            check_output("done_busy", busy, 0);
            check_output("done_scan_pulses", scan_count, 1);
            check_output("done_tx_bytes", tx_count, 2 * N);
            if (r.tmo) begin
              checks++;
              if (since_rx < TMO - 2 || since_rx > TMO + 4) begin
                errors++;
                $display("[TB] FAIL timeout_latency actual=%0d expected=%0d..%0d",
                         since_rx, TMO - 2, TMO + 4);
              end
            end
          end
          check_output("stim_wait_bound", stim_fails, 0);
          awaiting       = 0;
          runs_completed = seen_run;
        end else if (run_cycles > RUN_BUDGET) begin
          check_output("run_done_within_budget", run_cycles, RUN_BUDGET);
          awaiting       = 0;
          runs_completed = seen_run;
        end
      end
    end
    done_q = done;
    scan_q = scan_memory;
  end

  // One clock of input driving: sender ready, clock enable, start, echo and stray traffic.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    cyc++;
    ce = (ce_mode == 0) ? 1'b1 : ((cyc % 3) != 0);
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom % 2) == 1;
      default: tx_ready = 1'b0;
    endcase
    start    = 1'b0;
    rx_valid = 1'b0;
    if (start_pending && ce) begin
      start         = 1'b1;
      start_pending = 0;
    end else if (stray_mode && busy && ($urandom % 9) == 0) begin
      start = 1'b1;
    end
    if (echo_armed && scan_memory) begin
      for (int i = 0; i < stop_words; i++) begin
        rx_q.push_back(echo_words[i][15:8]);
        rx_q.push_back(echo_words[i][7:0]);
      end
      echo_armed = 0;
      gap        = 1;
    end
    if (!echo_armed && rx_q.size() != 0 && ce) begin
      if (gap > 0) gap--;
      else begin
        rx_byte  = rx_q.pop_front();
        rx_valid = 1'b1;
        gap      = $urandom_range(1, 3);
      end
    end else if (stray_mode && echo_armed && ce && ($urandom % 5) == 0) begin
      rx_valid = 1'b1;
      rx_byte  = 8'($urandom);
    end
  endtask

  // Reference model: byte stream, echoed words and the final verdict of one transfer.
  task automatic prepare_run(input int stop_after, input logic [N-1:0] corrupt);
    result_t res;
    int errs = 0;
    exp_tx.delete();
    rx_q.delete();
    stop_words = stop_after;
    for (int i = 0; i < N; i++) begin
      exp_tx.push_back(rom[i][15:8]);
      exp_tx.push_back(rom[i][7:0]);
      echo_words[i] = corrupt[i] ? (rom[i] ^ (16'h0001 << $urandom_range(0, 15))) : rom[i];
      if (i < stop_after && echo_words[i] != rom[i]) errs++;
    end
    res.errs     = 8'(errs > N ? N : errs);
    res.tmo      = stop_after < N;
    res.pass_exp = (errs == 0) && (stop_after >= N);
    exp_res.push_back(res);
  endtask

  task automatic run_transfer(input int rdy, input int cem, input int stop_after,
                              input bit stray, input logic [N-1:0] corrupt);
    ready_mode = rdy;
    ce_mode    = cem;
    stray_mode = stray;
    prepare_run(stop_after, corrupt);
    echo_armed    = 1;
    start_pending = 1;
    run_id++;
    while (runs_completed != run_id) apply_stimulus();
  endtask

  task automatic reset_mid_send();
    int waited = 0;
    ready_mode = 0;
    ce_mode    = 0;
    stray_mode = 0;
    prepare_run(N, '0);
    void'(exp_res.pop_back());
    echo_armed    = 0;
    start_pending = 1;
    run_id++;
    while (tx_count != 41 && waited < 5000) begin
      apply_stimulus();
      waited++;
    end
    if (waited >= 5000) stim_fails++;
    tx_ready = 1'b0;
    #2 rst = 1'b1;
    ready_mode = 2;
    repeat (3) apply_stimulus();
    rst = 1'b0;
    exp_tx.delete();
  endtask

  initial begin
    logic [N-1:0] corrupt;
    rst = 1'b1; ce = 1'b0; start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_byte = '0;
    for (int i = 0; i < N; i++) rom[i] = 16'hA500 + 16'(i);
    repeat (3) apply_stimulus();
    rst = 1'b0;

    $display("[TB] clean transfer");
    run_transfer(0, 0, N, 0, '0);

    $display("[TB] words 3 and 63 corrupted");
    corrupt = '0; corrupt[3] = 1'b1; corrupt[63] = 1'b1;
    run_transfer(0, 0, N, 0, corrupt);

    $display("[TB] random image, random ready, gated ce");
    for (int i = 0; i < N; i++) rom[i] = 16'($urandom);
    corrupt = '0;
    repeat (5) corrupt[$urandom_range(0, N - 1)] = 1'b1;
    run_transfer(1, 1, N, 0, corrupt);
    run_transfer(1, 1, N, 0, '0);

    for (int i = 0; i < N; i++) rom[i] = 16'hA500 + 16'(i);
    $display("[TB] echo stops after 10 words");
    run_transfer(0, 0, 10, 0, '0);

    $display("[TB] reset during word 20");
    reset_mid_send();
    run_transfer(1, 0, N, 0, '0);

    $display("[TB] stray rx bytes and start pulses");
    run_transfer(0, 0, N, 1, '0);
    run_transfer(1, 1, N, 1, '0);

    repeat (4) apply_stimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
